turbo_frame_ctrl: RTL and testbench

- Frame sequencer for the 8-bit turbo encoder datapath.
- Buffers one K-bit information frame from a byte stream, then steps the two constituent RSC encoders: encoder 1 in natural order, encoder 2 in QPP-interleaved order.
- Runs trellis termination, then pulses frame_done.
- The RSC parity logic and output packing stay in the encoder datapath; this block only sequences them.

---
 rtl/turbo_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_turbo_frame_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/turbo_frame_ctrl.sv
// Frame sequencer for the turbo encoder: buffers one K-bit frame from a byte stream,
// then steps both RSC encoders (natural and QPP-interleaved order) and terminates the trellis.
`timescale 1ns/1ps
module turbo_frame_ctrl #(
  parameter int K        = 64,
  parameter int F1       = 7,
  parameter int F2       = 16,
  parameter int TAIL_LEN = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 enc_ready,
  output logic                 enc_clear,
  output logic                 enc_step,
  output logic                 enc_term,
  output logic                 enc_u1,
  output logic                 enc_u2,
  output logic [$clog2(K)-1:0] bit_idx,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           dbg_state
);

  localparam int LW = $clog2(K);
  localparam int BW = LW - 3;
  localparam int TW = (TAIL_LEN > 1) ? $clog2(TAIL_LEN) : 1;

  localparam logic [LW-1:0] G0        = LW'((F1 + F2) % K);
  localparam logic [LW-1:0] DG        = LW'((2 * F2) % K);
  localparam logic [LW-1:0] LAST_BIT  = LW'(K - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(K / 8 - 1);
  localparam logic [TW-1:0] LAST_TAIL = TW'(TAIL_LEN - 1);

  typedef enum logic [2:0] {
    S_LOAD   = 3'd0,
    S_CLEAR  = 3'd1,
    S_ENCODE = 3'd2,
    S_TAIL   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          r_state;
  logic [K-1:0]    r_buf;
  logic [BW-1:0]   r_bcnt;
  logic [LW-1:0]   r_i;
  logic [LW-1:0]   r_pi;
  logic [LW-1:0]   r_g;
  logic [TW-1:0]   r_tcnt;

  logic w_encode;
  logic w_tail;

  assign w_encode = (r_state == S_ENCODE);
  assign w_tail   = (r_state == S_TAIL);

  // Handshakes: a byte transfers on a rising edge where in_valid && in_ready; an encoder
  // step happens on a rising edge where enc_step is high, and enc_step never rises without enc_ready.
  assign in_ready   = (r_state == S_LOAD);
  assign busy       = (r_state != S_LOAD);
  assign enc_clear  = (r_state == S_CLEAR);
  assign frame_done = (r_state == S_DONE);
  assign enc_term   = w_tail;
  assign enc_step   = (w_encode || w_tail) && enc_ready;
  assign enc_u1     = w_encode && r_buf[r_i];
  assign enc_u2     = w_encode && r_buf[r_pi];
  assign bit_idx    = r_i;
  assign dbg_state  = r_state;

  // pi(i) = F1*i + F2*i^2 is walked incrementally: its first difference g grows by 2*F2 per step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOAD;
      r_buf   <= '0;
      r_bcnt  <= '0;
      r_i     <= '0;
      r_pi    <= '0;
      r_g     <= '0;
      r_tcnt  <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          if (in_valid) begin
            r_buf[{r_bcnt, 3'b000} +: 8] <= in_data;
            r_bcnt <= r_bcnt + 1'b1;
            if (r_bcnt == LAST_BYTE) r_state <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_i     <= '0;
          r_pi    <= '0;
          r_g     <= G0;
          r_state <= S_ENCODE;
        end
        S_ENCODE: begin
          if (enc_ready) begin
            r_i  <= r_i + 1'b1;
            r_pi <= r_pi + r_g;
            r_g  <= r_g + DG;
            if (r_i == LAST_BIT) begin
              r_tcnt  <= '0;
              r_state <= S_TAIL;
            end
          end
        end
        S_TAIL: begin
          if (enc_ready) begin
            r_tcnt <= r_tcnt + 1'b1;
            if (r_tcnt == LAST_TAIL) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcnt  <= '0;
          r_state <= S_LOAD;
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_turbo_frame_ctrl.sv
// Directed-sequence bench for turbo_frame_ctrl with random data/backpressure,
// checked against a frame-level model of the QPP interleaver and step counts.
`timescale 1ns/1ps
module tb_turbo_frame_ctrl;
  localparam int K  = 64;
  localparam int F1 = 7;
  localparam int F2 = 16;
  localparam int TL = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       enc_ready;
  logic       enc_clear;
  logic       enc_step;
  logic       enc_term;
  logic       enc_u1;
  logic       enc_u2;
  logic [5:0] bit_idx;
  logic       busy;
  logic       frame_done;
  logic [2:0] dbg_state;

  turbo_frame_ctrl #(.K(K), .F1(F1), .F2(F2), .TAIL_LEN(TL)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .enc_ready(enc_ready), .enc_clear(enc_clear), .enc_step(enc_step), .enc_term(enc_term),
    .enc_u1(enc_u1), .enc_u2(enc_u2), .bit_idx(bit_idx), .busy(busy),
    .frame_done(frame_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int         n_chk = 0;
  int         n_err = 0;
  logic [7:0] fb [8];
  logic [K-1:0] mbuf;
  int         ready_mode;
  bit         hold_valid;
  int         u1_hits[$];
  int         u2_hits[$];
  int         act_steps, act_term, act_clear;
  int         inv  [K];
  int         seen [K];
  int         cyc;
  bit         hit30;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pi_of(input int i);
    return (F1 * i + F2 * i * i) % K;
  endfunction

  // Starts at a falling edge in LOAD; returns at the falling edge of the CLEAR cycle.
  task automatic load_frame();
    for (int b = 0; b < 8; b++) begin
      in_valid = 1'b1;
      in_data  = fb[b];
      for (int k = 0; k < 8; k++) mbuf[8*b+k] = fb[b][k];
      #1;
      check("load_in_ready", in_ready, 1);
      check("load_busy", busy, 0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Walks CLEAR, the K+TL steps and DONE, checking each cycle against the frame model.
  task automatic encode_frame();
    int c = 0;
    int n = 0;
    bit done = 1'b0;
    u1_hits.delete();
    u2_hits.delete();
    act_steps = 0;
    act_term  = 0;
    act_clear = 0;
    while (!done && c < 2000) begin
      c++;
      enc_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = hold_valid;
      if (hold_valid) in_data = in_data + 8'd1;
      #1;
      if (enc_step) act_steps++;
      if (enc_step && enc_term) act_term++;
      if (enc_clear) act_clear++;
      check("busy_in_frame", busy, 1);
      check("in_ready_in_frame", in_ready, 0);
      if (c == 1) begin
        check("clear_pulse", enc_clear, 1);
        check("clear_no_step", enc_step, 0);
        check("clear_no_done", frame_done, 0);
      end else if (n < K + TL) begin
        check("step_no_clear", enc_clear, 0);
        check("step_no_done", frame_done, 0);
        check("step_vs_ready", enc_step, enc_ready);
        if (n < K) begin
          check("enc_term_low", enc_term, 0);
          check("bit_idx", bit_idx, n);
          check("enc_u1", enc_u1, mbuf[n]);
          check("enc_u2", enc_u2, mbuf[pi_of(n)]);
        end else begin
          check("enc_term_high", enc_term, 1);
          check("tail_u1", enc_u1, 0);
          check("tail_u2", enc_u2, 0);
        end
        if (enc_ready) begin
          if (n < K && enc_u1) u1_hits.push_back(n);
          if (n < K && enc_u2) u2_hits.push_back(n);
          n++;
        end
      end else begin
        check("frame_done", frame_done, 1);
        check("done_no_step", enc_step, 0);
        check("done_no_term", enc_term, 0);
        check("done_no_clear", enc_clear, 0);
        if (ready_mode == 0) check("latency", c, 1 + K + TL + 1);
        done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("frame_end_seen", done, 1);
    check("total_steps", act_steps, K + TL);
    check("tail_steps", act_term, TL);
    check("clear_count", act_clear, 1);
    in_valid = hold_valid;
    #1;
    check("back_to_load", in_ready, 1);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    enc_ready  = 1'b0;
    ready_mode = 0;
    hold_valid = 1'b0;

    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_enc_clear", enc_clear, 0);
    check("rst_enc_step", enc_step, 0);
    check("rst_enc_term", enc_term, 0);
    check("rst_enc_u1", enc_u1, 0);
    check("rst_enc_u2", enc_u2, 0);
    check("rst_bit_idx", bit_idx, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;

    // All-zero frame with the datapath always ready
    for (int b = 0; b < 8; b++) fb[b] = 8'h00;
    load_frame();
    encode_frame();

    // Interleaver order from two isolated bits
    for (int b = 0; b < 8; b++) fb[b] = 8'h00;
    fb[1] = 8'h40;
    fb[2] = 8'h80;
    load_frame();
    encode_frame();
    check("u2_hit_count", u2_hits.size(), 2);
    check("u2_hit0", (u2_hits.size() > 0) ? u2_hits[0] : -1, 1);
    check("u2_hit1", (u2_hits.size() > 1) ? u2_hits[1] : -1, 2);
    check("u1_hit_count", u1_hits.size(), 2);
    check("u1_hit0", (u1_hits.size() > 0) ? u1_hits[0] : -1, 14);
    check("u1_hit1", (u1_hits.size() > 1) ? u1_hits[1] : -1, 23);

    // Random data under random backpressure
    ready_mode = 1;
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 8; b++) fb[b] = 8'($urandom_range(0, 255));
      load_frame();
      encode_frame();
    end
    ready_mode = 0;

    // Continuous in_valid across two frames
    hold_valid = 1'b1;
    for (int b = 0; b < 8; b++) fb[b] = 8'(b);
    load_frame();
    encode_frame();
    for (int b = 0; b < 8; b++) fb[b] = 8'(b + 8);
    load_frame();
    hold_valid = 1'b0;
    encode_frame();

    // One-hot sweep recovers the inverse permutation from the enc_u2 stream
    for (int j = 0; j < K; j++) begin
      for (int b = 0; b < 8; b++) fb[b] = 8'h00;
      fb[j / 8][j % 8] = 1'b1;
      load_frame();
      encode_frame();
      check("onehot_u2_count", u2_hits.size(), 1);
      check("onehot_u1_count", u1_hits.size(), 1);
      check("onehot_u1_pos", (u1_hits.size() > 0) ? u1_hits[0] : -1, j);
      inv[j] = (u2_hits.size() > 0) ? u2_hits[0] : -1;
    end
    for (int i = 0; i < K; i++) seen[i] = 0;
    for (int j = 0; j < K; j++) if (inv[j] >= 0 && inv[j] < K) seen[inv[j]]++;
    for (int i = 0; i < K; i++) check("perm_unique", seen[i], 1);
    check("pi_seq_0", inv[0], 0);
    check("pi_seq_1", inv[23], 1);
    check("pi_seq_2", inv[14], 2);
    check("pi_seq_3", inv[37], 3);

    // Reset mid-frame at i = 30, then a clean frame
    for (int b = 0; b < 8; b++) fb[b] = 8'($urandom_range(0, 255));
    load_frame();
    hit30 = 1'b0;
    cyc   = 0;
    in_valid = 1'b0;
    while (!hit30 && cyc < 200) begin
      enc_ready = 1'b1;
      #1;
      if (bit_idx == 6'd30 && enc_step) hit30 = 1'b1;
      else begin
        cyc++;
        @(posedge clk);
        @(negedge clk);
      end
    end
    check("reached_i30", hit30, 1);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_step", enc_step, 0);
    check("midrst_term", enc_term, 0);
    check("midrst_done", frame_done, 0);
    check("midrst_clear", enc_clear, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_bit_idx", bit_idx, 0);
    check("midrst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int b = 0; b < 8; b++) fb[b] = 8'($urandom_range(0, 255));
    load_frame();
    encode_frame();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
